// File: rtl/multi_capture_pkg.sv
// +--------------------------------------------------------------------------+
// | multi_capture_pkg                                                        |
// | Shared state encoding and header word layout for multi_channel_capture.  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

package multi_capture_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE     = 3'b000;
  localparam state_t S_ARMED    = 3'b010;
  localparam state_t S_POST     = 3'b100;
  localparam state_t S_CAPTURED = 3'b011;
  localparam state_t S_READOUT  = 3'b001;

  // Header word: {magic, channel, trigger address truncated to WIDTH-8 bits}
  localparam logic [3:0] HDR_MAGIC   = 4'hA;
  localparam int         HDR_CHAN_W  = 4;
  localparam int         HDR_FIXED_W = 8;

endpackage

`default_nettype wire

// File: rtl/capture_ram.sv
// +--------------------------------------------------------------------------+
// | capture_ram                                                              |
// | Simple dual-port sample memory, 2^SIZE x WIDTH, registered read.         |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module capture_ram #(
  parameter int SIZE  = 8,
  parameter int WIDTH = 12
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [SIZE-1:0]  waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [SIZE-1:0]  raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] r_mem [2**SIZE];

  always_ff @(posedge CLK) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
    rdata <= r_mem[raddr];
  end

endmodule

`default_nettype wire

// File: rtl/multi_channel_capture.sv
// +--------------------------------------------------------------------------+
// | multi_channel_capture                                                    |
// | NCH-channel pre-trigger ring capture with channel-serial valid/ready     |
// | readout. Optional per-channel header words: define CAPTURE_HEADER_EN.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module multi_channel_capture
  import multi_capture_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int SIZE  = 8,
  parameter int WIDTH = 12,
  parameter int CW    = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic               CLK,
  input  logic               RESET_N,
  input  logic               sample_valid,
  input  logic [NCH*WIDTH-1:0] sample_data,
  input  logic               arm,
  input  logic               trigger,
  input  logic [SIZE-1:0]    howmany,
  input  logic [SIZE-1:0]    offset,
  input  logic               rd_request,
  output logic [WIDTH-1:0]   dout,
  output logic [CW-1:0]      dout_chan,
  output logic               dout_valid,
  input  logic               dout_ready,
  output logic               dout_last,
  output logic               captured,
  output logic               busy
);

`ifdef CAPTURE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam logic [SIZE-1:0] c_fill_max = '1;

  state_t           r_state, w_next;
  logic [SIZE-1:0]  r_wr_ptr, r_fill, r_hm, r_start, r_post_cnt;
  logic [CW-1:0]    r_rd_chan;
  logic [SIZE:0]    r_rd_idx;
  logic             r_issue_done;

  logic             r_pvalid, r_plast;
  logic [CW-1:0]    r_pchan;

  logic             r_v0, r_v1, r_l0, r_l1;
  logic [WIDTH-1:0] r_w0, r_w1;
  logic [CW-1:0]    r_c0, r_c1;

  logic [SIZE-1:0]  w_off_eff, w_remain, w_raddr;
  logic [SIZE:0]    w_wpc;
  logic [1:0]       w_occ;
  logic             w_write, w_trig_ok, w_none, w_pop, w_issue, w_chan_end, w_done;
  logic [WIDTH-1:0] w_rdata [NCH];
  logic [WIDTH-1:0] w_sel, w_pword;

  always_comb begin
    w_off_eff = '0;
    if (howmany != '0) begin
      w_off_eff = (offset < howmany) ? offset : howmany - SIZE'(1);
    end
  end

  assign w_remain   = howmany - w_off_eff - SIZE'(1);
  assign w_write    = sample_valid && arm && ((r_state == S_ARMED) || (r_state == S_POST));
  assign w_trig_ok  = (r_state == S_ARMED) && arm && sample_valid && trigger && (r_fill >= w_off_eff);
  assign w_wpc      = {1'b0, r_hm} + (SIZE+1)'(HDR);
  assign w_none     = (w_wpc == '0);
  assign w_pop      = r_v0 && dout_ready;
  assign w_chan_end = (r_rd_idx == w_wpc - (SIZE+1)'(1));
  assign w_raddr    = r_start + r_rd_idx[SIZE-1:0] - SIZE'(HDR);

  // Issue a read only if its data is guaranteed a slot in the skid buffer.
  assign w_occ   = {1'b0, r_v0} + {1'b0, r_v1} + {1'b0, r_pvalid} - {1'b0, w_pop};
  assign w_issue = !r_issue_done && !w_none && (w_occ <= 2'd1) &&
                   ((r_state == S_READOUT) || ((r_state == S_CAPTURED) && rd_request && arm));
  assign w_done  = (r_state == S_READOUT) && ((w_pop && r_l0) || w_none);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:     if (arm) w_next = S_ARMED;
      S_ARMED: begin
        if (!arm) begin
          w_next = S_IDLE;
        end else if (w_trig_ok) begin
          w_next = ((howmany == '0) || (w_remain == '0)) ? S_CAPTURED : S_POST;
        end
      end
      S_POST: begin
        if (!arm) begin
          w_next = S_IDLE;
        end else if (sample_valid && (r_post_cnt == SIZE'(1))) begin
          w_next = S_CAPTURED;
        end
      end
      S_CAPTURED: begin
        if (!arm) begin
          w_next = S_IDLE;
        end else if (rd_request) begin
          w_next = S_READOUT;
        end
      end
      S_READOUT:  if (w_done) w_next = arm ? S_ARMED : S_IDLE;
      default:    w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy     = (r_state != S_IDLE);
    captured = (r_state == S_CAPTURED);
  end

  genvar g;
  generate
    for (g = 0; g < NCH; g++) begin : g_ch
      capture_ram #(.SIZE(SIZE), .WIDTH(WIDTH)) u_ram (
        .CLK   (CLK),
        .we    (w_write),
        .waddr (r_wr_ptr),
        .wdata (sample_data[g*WIDTH +: WIDTH]),
        .raddr (w_raddr),
        .rdata (w_rdata[g])
      );
    end
  endgenerate

  assign w_sel = w_rdata[r_pchan];

`ifdef CAPTURE_HEADER_EN
  logic [SIZE-1:0]  r_trig;
  logic             r_phdr;
  logic [WIDTH-1:0] w_t_ext;

  assign w_t_ext = WIDTH'(r_trig);
  assign w_pword = r_phdr ? {HDR_MAGIC, HDR_CHAN_W'(r_pchan), w_t_ext[WIDTH-HDR_FIXED_W-1:0]} : w_sel;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_trig <= '0;
      r_phdr <= 1'b0;
    end else begin
      if (w_trig_ok) r_trig <= r_wr_ptr;
      r_phdr <= (r_rd_idx == '0);
    end
  end
`else
  assign w_pword = w_sel;
`endif

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_wr_ptr     <= '0;
      r_fill       <= '0;
      r_hm         <= '0;
      r_start      <= '0;
      r_post_cnt   <= '0;
      r_rd_chan    <= '0;
      r_rd_idx     <= '0;
      r_issue_done <= 1'b1;
      r_pvalid     <= 1'b0;
      r_plast      <= 1'b0;
      r_pchan      <= '0;
    end else begin
      if (w_write) r_wr_ptr <= r_wr_ptr + SIZE'(1);

      if ((r_state != S_ARMED) && (w_next == S_ARMED)) begin
        r_fill <= '0;
      end else if ((r_state == S_ARMED) && w_write && (r_fill != c_fill_max)) begin
        r_fill <= r_fill + SIZE'(1);
      end

      if (w_trig_ok) begin
        r_hm         <= howmany;
        r_start      <= r_wr_ptr - w_off_eff;
        r_post_cnt   <= w_remain;
        r_rd_chan    <= '0;
        r_rd_idx     <= '0;
        r_issue_done <= 1'b0;
      end else begin
        if ((r_state == S_POST) && w_write) r_post_cnt <= r_post_cnt - SIZE'(1);
        if (w_issue) begin
          if (w_chan_end) begin
            r_rd_idx <= '0;
            if (r_rd_chan == CW'(NCH-1)) begin
              r_issue_done <= 1'b1;
            end else begin
              r_rd_chan <= r_rd_chan + CW'(1);
            end
          end else begin
            r_rd_idx <= r_rd_idx + (SIZE+1)'(1);
          end
        end
      end

      r_pvalid <= w_issue;
      r_pchan  <= r_rd_chan;
      r_plast  <= w_chan_end && (r_rd_chan == CW'(NCH-1));
    end
  end

  // Two-entry skid buffer; entry 0 drives the output port.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_v0 <= 1'b0;
      r_v1 <= 1'b0;
      r_w0 <= '0;
      r_w1 <= '0;
      r_c0 <= '0;
      r_c1 <= '0;
      r_l0 <= 1'b0;
      r_l1 <= 1'b0;
    end else if (!r_v0 || w_pop) begin
      if (r_v1) begin
        r_v0 <= 1'b1;
        r_w0 <= r_w1;
        r_c0 <= r_c1;
        r_l0 <= r_l1;
        if (r_pvalid) begin
          r_w1 <= w_pword;
          r_c1 <= r_pchan;
          r_l1 <= r_plast;
        end else begin
          r_v1 <= 1'b0;
        end
      end else if (r_pvalid) begin
        r_v0 <= 1'b1;
        r_w0 <= w_pword;
        r_c0 <= r_pchan;
        r_l0 <= r_plast;
      end else begin
        r_v0 <= 1'b0;
      end
    end else if (r_pvalid) begin
      r_v1 <= 1'b1;
      r_w1 <= w_pword;
      r_c1 <= r_pchan;
      r_l1 <= r_plast;
    end
  end

  assign dout       = r_w0;
  assign dout_chan  = r_c0;
  assign dout_valid = r_v0;
  assign dout_last  = r_v0 && r_l0;

endmodule

`default_nettype wire

// File: tb/tb_multi_channel_capture.sv
// +--------------------------------------------------------------------------+
// | tb_multi_channel_capture                                                 |
// | Self-checking bench against a sample-history reference model.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_multi_channel_capture;

  localparam int NCH   = 4;
  localparam int SIZE  = 4;
  localparam int WIDTH = 12;
  localparam int CW    = 2;
  localparam int DEPTH = 1 << SIZE;
`ifdef CAPTURE_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif

  logic                 CLK, RESET_N;
  logic                 sample_valid, arm, trigger, rd_request, dout_ready;
  logic [NCH*WIDTH-1:0] sample_data;
  logic [SIZE-1:0]      howmany, offset;
  logic [WIDTH-1:0]     dout;
  logic [CW-1:0]        dout_chan;
  logic                 dout_valid, dout_last, captured, busy;

  multi_channel_capture #(.NCH(NCH), .SIZE(SIZE), .WIDTH(WIDTH)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .sample_valid(sample_valid), .sample_data(sample_data),
    .arm(arm), .trigger(trigger), .howmany(howmany), .offset(offset),
    .rd_request(rd_request), .dout(dout), .dout_chan(dout_chan), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_last(dout_last), .captured(captured), .busy(busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: samples written since the session was armed.
  logic [NCH*WIDTH-1:0] m_hist[$];
  int m_phase;  // 0 idle, 1 armed, 2 post, 3 captured
  int m_tidx, m_hm, m_off, m_remain, m_wr, m_taddr;

  logic [WIDTH-1:0] exp_w[$], got_w[$];
  int               exp_c[$], got_c[$];
  bit               exp_l[$], got_l[$];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic arm_on();
    arm = 1'b1;
    tick();
    m_phase = 1;
    m_hist.delete();
  endtask

  task automatic drive_sample(input bit trig, input bit rnd);
    logic [NCH*WIDTH-1:0] d;
    int hm_i, of_i, oe;
    for (int c = 0; c < NCH; c++) begin
      d[c*WIDTH +: WIDTH] = rnd ? WIDTH'($urandom) : WIDTH'(100*c + m_hist.size());
    end
    hm_i = int'(howmany);
    of_i = int'(offset);
    oe   = (hm_i == 0) ? 0 : ((of_i < hm_i) ? of_i : hm_i - 1);
    if (!arm) begin
      m_phase = 0;
    end else if (m_phase == 1) begin
      if (trig && m_hist.size() >= oe) begin
        m_tidx   = m_hist.size();
        m_hm     = hm_i;
        m_off    = oe;
        m_taddr  = m_wr % DEPTH;
        m_remain = (hm_i == 0) ? 0 : hm_i - oe - 1;
        m_phase  = (m_remain == 0) ? 3 : 2;
      end
      m_hist.push_back(d);
      m_wr++;
    end else if (m_phase == 2) begin
      m_hist.push_back(d);
      m_wr++;
      m_remain--;
      if (m_remain == 0) m_phase = 3;
    end
    sample_valid = 1'b1;
    sample_data  = d;
    trigger      = trig;
    tick();
    sample_valid = 1'b0;
    trigger      = 1'b0;
  endtask

  task automatic build_expected();
    logic [NCH*WIDTH-1:0] v;
    int hv;
    exp_w.delete(); exp_c.delete(); exp_l.delete();
    for (int c = 0; c < NCH; c++) begin
      if (HDR == 1) begin
        hv = (10 << (WIDTH-4)) | (c << (WIDTH-8)) | (m_taddr & ((1 << (WIDTH-8)) - 1));
        exp_w.push_back(WIDTH'(hv)); exp_c.push_back(c); exp_l.push_back(1'b0);
      end
      for (int i = 0; i < m_hm; i++) begin
        v = m_hist[m_tidx - m_off + i];
        exp_w.push_back(v[c*WIDTH +: WIDTH]); exp_c.push_back(c); exp_l.push_back(1'b0);
      end
    end
    if (exp_l.size() > 0) exp_l[exp_l.size()-1] = 1'b1;
  endtask

  // Pulses rd_request and gathers every handshaken word.
  task automatic collect(input int ready_pct, output int first_valid, output int unstable,
                         output bit timeout);
    logic [WIDTH-1:0] pw;
    int pc, extra;
    bit pl, hold;
    got_w.delete(); got_c.delete(); got_l.delete();
    first_valid = -1; unstable = 0; hold = 0; extra = 4; timeout = 0;
    pw = '0; pc = 0; pl = 0;
    rd_request = 1'b1;
    tick();
    rd_request = 1'b0;
    for (int k = 1; k < 600; k++) begin
      if (hold && (!dout_valid || dout !== pw || int'(dout_chan) != pc || dout_last !== pl)) unstable++;
      if (dout_valid && first_valid < 0) first_valid = k;
      dout_ready = (got_w.size() >= exp_w.size()) ? 1'b1 : ($urandom_range(99) < ready_pct);
      if (dout_valid && dout_ready) begin
        got_w.push_back(dout); got_c.push_back(int'(dout_chan)); got_l.push_back(dout_last);
      end
      hold = dout_valid && !dout_ready;
      pw = dout; pc = int'(dout_chan); pl = dout_last;
      tick();
      if (got_w.size() >= exp_w.size()) extra--;
      if (extra == 0) break;
    end
    if (got_w.size() < exp_w.size()) timeout = 1;
    dout_ready = 1'b0;
    m_phase = arm ? 1 : 0;
    m_hist.delete();
  endtask

  task automatic test_reset();
    RESET_N = 1'b0; arm = 0; trigger = 0; sample_valid = 0; sample_data = '0;
    rd_request = 0; dout_ready = 0; howmany = '0; offset = '0;
    m_phase = 0; m_wr = 0;
    #12;
    n_total++;
    if ({dout, dout_chan, dout_valid, dout_last, captured, busy} !== '0)
      $display("FAIL reset_outputs: got %h required 0", {dout, dout_chan, dout_valid, dout_last, captured, busy});
    else n_pass++;
    tick();
    RESET_N = 1'b1;
    tick();
    n_total++;
    if ({dout_valid, captured, busy} !== 3'b000)
      $display("FAIL reset_release: got %b required 000", {dout_valid, captured, busy});
    else n_pass++;
  endtask

  task automatic test_basic_window();
    int fv, un; bit to;
    offset = 4'd3; howmany = 4'd8;
    arm_on();
    for (int n = 0; n < 20; n++) drive_sample(0, 0);
    drive_sample(1, 0);
    for (int i = 0; i < 4; i++) begin
      n_total++;
      if (captured !== 1'b0) $display("FAIL basic_captured_early: got %b required 0 at post %0d", captured, i);
      else n_pass++;
      drive_sample(0, 0);
    end
    n_total++;
    if (captured !== 1'b1) $display("FAIL basic_captured: got %b required 1", captured);
    else n_pass++;
    build_expected();
    collect(100, fv, un, to);
    n_total++;
    if (fv != 2) $display("FAIL basic_latency: got %0d required 2", fv); else n_pass++;
    n_total++;
    if (got_w.size() != exp_w.size() || to) $display("FAIL basic_count: got %0d required %0d", got_w.size(), exp_w.size());
    else n_pass++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      n_total++;
      if ({got_w[i], 4'(got_c[i]), got_l[i]} !== {exp_w[i], 4'(exp_c[i]), exp_l[i]})
        $display("FAIL basic_word[%0d]: got %h/%0d/%b required %h/%0d/%b", i, got_w[i], got_c[i], got_l[i], exp_w[i], exp_c[i], exp_l[i]);
      else n_pass++;
    end
    n_total++;
    if (got_w.size() > HDR && got_w[HDR] !== 12'd17) $display("FAIL basic_first_sample: got %0d required 17", got_w[HDR]);
    else n_pass++;
    n_total++;
    if ({busy, captured, dout_valid} !== 3'b100) $display("FAIL basic_rearm: got %b required 100", {busy, captured, dout_valid});
    else n_pass++;
  endtask

  task automatic test_insufficient_history();
    int fv, un; bit to;
    offset = 4'd5; howmany = 4'd8;
    drive_sample(0, 0); drive_sample(0, 0);
    drive_sample(1, 0);
    drive_sample(0, 0);
    drive_sample(1, 0);
    n_total++;
    if (captured !== 1'b0 || busy !== 1'b1) $display("FAIL hist_gate_ignored: got cap=%b busy=%b required 0/1", captured, busy);
    else n_pass++;
    drive_sample(1, 0);
    for (int i = 0; i < 2; i++) drive_sample(0, 0);
    n_total++;
    if (captured !== 1'b1) $display("FAIL hist_gate_accept: got %b required 1", captured); else n_pass++;
    build_expected();
    collect(100, fv, un, to);
    n_total++;
    if (got_w.size() != exp_w.size() || to) $display("FAIL hist_count: got %0d required %0d", got_w.size(), exp_w.size());
    else n_pass++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      n_total++;
      if ({got_w[i], 4'(got_c[i]), got_l[i]} !== {exp_w[i], 4'(exp_c[i]), exp_l[i]})
        $display("FAIL hist_word[%0d]: got %h/%0d/%b required %h/%0d/%b", i, got_w[i], got_c[i], got_l[i], exp_w[i], exp_c[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_wrap();
    int fv, un; bit to;
    offset = 4'd5; howmany = 4'd10;
    for (int g = 0; g < 40 && !(m_hist.size() >= 5 && (m_wr % DEPTH) == 1); g++) drive_sample(0, 1);
    drive_sample(1, 1);
    for (int g = 0; g < 20 && m_phase == 2; g++) drive_sample(0, 1);
    n_total++;
    if (captured !== 1'b1 || m_taddr != 1) $display("FAIL wrap_captured: got %b T=%0d required 1 T=1", captured, m_taddr);
    else n_pass++;
    build_expected();
    collect(100, fv, un, to);
    n_total++;
    if (got_w.size() != exp_w.size() || to) $display("FAIL wrap_count: got %0d required %0d", got_w.size(), exp_w.size());
    else n_pass++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      n_total++;
      if ({got_w[i], 4'(got_c[i]), got_l[i]} !== {exp_w[i], 4'(exp_c[i]), exp_l[i]})
        $display("FAIL wrap_word[%0d]: got %h/%0d/%b required %h/%0d/%b", i, got_w[i], got_c[i], got_l[i], exp_w[i], exp_c[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    int fv, un, hm, of, oe; bit to;
    for (int r = 0; r < 4; r++) begin
      hm = $urandom_range(1, 15);
      of = $urandom_range(0, (hm + 2 > 15) ? 15 : hm + 2);
      oe = (of < hm) ? of : hm - 1;
      howmany = SIZE'(hm); offset = SIZE'(of);
      for (int i = 0; i < oe + int'($urandom_range(0, 4)); i++) drive_sample(0, 1);
      drive_sample(1, 1);
      for (int g = 0; g < 20 && m_phase == 2; g++) drive_sample(0, 1);
      n_total++;
      if (captured !== 1'b1) $display("FAIL bp_captured[%0d]: got %b required 1", r, captured); else n_pass++;
      build_expected();
      collect(50, fv, un, to);
      n_total++;
      if (un != 0) $display("FAIL bp_stable[%0d]: got %0d unstable cycles required 0", r, un); else n_pass++;
      n_total++;
      if (got_w.size() != exp_w.size() || to) $display("FAIL bp_count[%0d]: got %0d required %0d", r, got_w.size(), exp_w.size());
      else n_pass++;
      for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
        n_total++;
        if ({got_w[i], 4'(got_c[i]), got_l[i]} !== {exp_w[i], 4'(exp_c[i]), exp_l[i]})
          $display("FAIL bp_word[%0d][%0d]: got %h/%0d/%b required %h/%0d/%b", r, i, got_w[i], got_c[i], got_l[i], exp_w[i], exp_c[i], exp_l[i]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_boundaries();
    int fv, un; bit to;
    offset = 4'd3; howmany = 4'd0;
    drive_sample(1, 1);
    n_total++;
    if (captured !== 1'b1) $display("FAIL hm0_captured: got %b required 1", captured); else n_pass++;
    build_expected();
    collect(100, fv, un, to);
    n_total++;
    if (got_w.size() != NCH*HDR || to) $display("FAIL hm0_count: got %0d required %0d", got_w.size(), NCH*HDR);
    else n_pass++;
    n_total++;
    if ({busy, captured, dout_valid} !== 3'b100) $display("FAIL hm0_return: got %b required 100", {busy, captured, dout_valid});
    else n_pass++;
    offset = 4'd9; howmany = 4'd4;
    for (int i = 0; i < 3; i++) drive_sample(0, 1);
    drive_sample(1, 1);
    n_total++;
    if (captured !== 1'b1) $display("FAIL off_clamp_captured: got %b required 1", captured); else n_pass++;
    build_expected();
    collect(70, fv, un, to);
    n_total++;
    if (got_w.size() != exp_w.size() || to) $display("FAIL off_clamp_count: got %0d required %0d", got_w.size(), exp_w.size());
    else n_pass++;
    for (int i = 0; i < exp_w.size() && i < got_w.size(); i++) begin
      n_total++;
      if ({got_w[i], 4'(got_c[i]), got_l[i]} !== {exp_w[i], 4'(exp_c[i]), exp_l[i]})
        $display("FAIL off_clamp_word[%0d]: got %h/%0d/%b required %h/%0d/%b", i, got_w[i], got_c[i], got_l[i], exp_w[i], exp_c[i], exp_l[i]);
      else n_pass++;
    end
  endtask

  task automatic test_abort();
    int bad;
    offset = 4'd1; howmany = 4'd8;
    drive_sample(0, 1); drive_sample(0, 1);
    drive_sample(1, 1);
    n_total++;
    if ({busy, captured} !== 2'b10 || m_phase != 2) $display("FAIL abort_post: got %b required 10", {busy, captured});
    else n_pass++;
    arm = 1'b0;
    tick();
    m_phase = 0;
    n_total++;
    if ({busy, captured} !== 2'b00) $display("FAIL abort_idle: got %b required 00", {busy, captured}); else n_pass++;
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      drive_sample(0, 1);
      if (captured !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL abort_stays_idle: got %0d bad cycles required 0", bad); else n_pass++;
    arm_on();
    for (int i = 0; i < 3; i++) drive_sample(0, 1);
    arm = 1'b0;
    drive_sample(1, 1);
    n_total++;
    if ({busy, captured} !== 2'b00) $display("FAIL abort_vs_trigger: got %b required 00", {busy, captured}); else n_pass++;
  endtask

  task automatic test_reset_mid_readout();
    int hs, bad;
    offset = 4'd2; howmany = 4'd8;
    arm_on();
    for (int i = 0; i < 4; i++) drive_sample(0, 1);
    drive_sample(1, 1);
    for (int g = 0; g < 20 && m_phase == 2; g++) drive_sample(0, 1);
    rd_request = 1'b1;
    tick();
    rd_request = 1'b0;
    dout_ready = 1'b1;
    hs = 0;
    for (int g = 0; g < 30 && hs < 5; g++) begin
      if (dout_valid) hs++;
      tick();
    end
    n_total++;
    if (hs != 5 || dout_valid !== 1'b1) $display("FAIL mid_readout_progress: got %0d words valid=%b required 5/1", hs, dout_valid);
    else n_pass++;
    #2;
    RESET_N = 1'b0;
    arm = 1'b0;
    #1;
    n_total++;
    if ({dout, dout_chan, dout_valid, dout_last, captured, busy} !== '0)
      $display("FAIL mid_reset_outputs: got %h required 0", {dout, dout_chan, dout_valid, dout_last, captured, busy});
    else n_pass++;
    tick(); tick();
    RESET_N = 1'b1;
    m_phase = 0; m_wr = 0; m_hist.delete();
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (dout_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_total++;
    if (bad != 0) $display("FAIL mid_reset_quiet: got %0d bad cycles required 0", bad); else n_pass++;
    dout_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic_window();
    test_insufficient_history();
    test_wrap();
    test_backpressure();
    test_boundaries();
    test_abort();
    test_reset_mid_readout();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

`default_nettype wire
